// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - state encoding shared by the shift-and-add multiplier
package mult_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_mult_if.sv
// rtl/shift_add_mult_if.sv - start/operand/result bundle of the multiplier
interface shift_add_mult_if #(
    parameter int WIDTH = 8
);
    logic                 st;
    logic                 sgn;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   product;
    logic                 idle;
    logic                 done;
    logic                 load;
    logic                 sh;
    logic                 ad;
    logic [1:0]           state;

    modport master (
        output st, sgn, mcand, mplier,
        input  product, idle, done, load, sh, ad, state
    );

    modport slave (
        input  st, sgn, mcand, mplier,
        output product, idle, done, load, sh, ad, state
    );
endinterface

// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - control FSM and iteration counter of the multiplier
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st,
    input  logic               m,
    output logic               k,
    output logic               idle,
    output logic               done,
    output logic               load,
    output logic               sh,
    output logic               ad,
    output logic [STATE_W-1:0] state
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    assign k     = (r_cnt == CNT_W'(WIDTH - 1));
    assign idle  = (r_state == S_IDLE);
    assign done  = (r_state == S_DONE);
    assign state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (load) begin
                r_cnt <= '0;
            end else if (sh) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Strobes are held low while rst is high so reset looks quiet to observers.
    always_comb begin
        w_next = r_state;
        load   = 1'b0;
        sh     = 1'b0;
        ad     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (st) begin
                        load   = 1'b1;
                        w_next = S_ADD;
                    end
                end
                S_ADD: begin
                    if (m) begin
                        ad     = 1'b1;
                        w_next = S_SHIFT;
                    end else begin
                        sh     = 1'b1;
                        w_next = k ? S_DONE : S_ADD;
                    end
                end
                S_SHIFT: begin
                    sh     = 1'b1;
                    w_next = k ? S_DONE : S_ADD;
                end
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-and-add multiplier, unsigned or sign-magnitude
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    shift_add_mult_if.slave  bus
);
    localparam int AW = 2*WIDTH + 1;

    logic [AW-1:0]        r_acc;
    logic [WIDTH-1:0]     r_mc;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_m;
    logic                 w_k;
    logic                 w_load;
    logic                 w_sh;
    logic                 w_ad;
    logic                 w_idle;
    logic                 w_done;
    logic [STATE_W-1:0]   w_state;
    logic [WIDTH-1:0]     w_mcand_abs;
    logic [WIDTH-1:0]     w_mplier_abs;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mag;
    logic [2*WIDTH-1:0]   w_prod_next;

    mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .st    (bus.st),
        .m     (w_m),
        .k     (w_k),
        .idle  (w_idle),
        .done  (w_done),
        .load  (w_load),
        .sh    (w_sh),
        .ad    (w_ad),
        .state (w_state)
    );

    // The most negative operand negates to itself, which reads correctly as unsigned.
    assign w_mcand_abs  = (bus.sgn && bus.mcand[WIDTH-1])  ? -bus.mcand  : bus.mcand;
    assign w_mplier_abs = (bus.sgn && bus.mplier[WIDTH-1]) ? -bus.mplier : bus.mplier;

    assign w_m         = r_acc[0];
    assign w_sum       = r_acc[AW-1:WIDTH] + {1'b0, r_mc};
    assign w_mag       = r_acc[2*WIDTH:1];
    assign w_prod_next = r_neg ? -w_mag : w_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mc      <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_load) begin
            r_acc     <= {{(WIDTH+1){1'b0}}, w_mplier_abs};
            r_mc      <= w_mcand_abs;
            r_neg     <= bus.sgn & (bus.mcand[WIDTH-1] ^ bus.mplier[WIDTH-1]);
            r_product <= '0;
        end else if (w_ad) begin
            r_acc[AW-1:WIDTH] <= w_sum;
        end else if (w_sh) begin
            r_acc <= {1'b0, r_acc[AW-1:1]};
            // Last shift: capture the shifted value on the same edge that enters S_DONE.
            if (w_k) begin
                r_product <= w_prod_next;
            end
        end
    end

    assign bus.product = r_product;
    assign bus.idle    = w_idle;
    assign bus.done    = w_done;
    assign bus.load    = w_load;
    assign bus.sh      = w_sh;
    assign bus.ad      = w_ad;
    assign bus.state   = w_state;
endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - scoreboard bench for shift_add_mult at WIDTH = 8
module tb_shift_add_mult;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_add_mult_if #(.WIDTH(W)) bus();
    shift_add_mult #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          nad;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   b2b   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    initial begin : monitor
        bit   running;
        bit   prev_done;
        int   cyc;
        int   nad;
        int   nsh;
        exp_t e;
        running   = 1'b0;
        prev_done = 1'b0;
        cyc = 0; nad = 0; nsh = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                running   = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.load) begin
                    if (b2b) check("b2b_load_after_done", 32'(prev_done), 32'd1);
                    running = 1'b1;
                    cyc = 0; nad = 0; nsh = 0;
                end else if (running) begin
                    cyc++;
                    nad += int'(bus.ad);
                    nsh += int'(bus.sh);
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL spurious_done: got done=1 required no done (product 0x%0h)", bus.product);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_product"}, 32'(bus.product), 32'(e.prod));
                        check({e.name, "_latency"}, 32'(cyc - 1), 32'(e.lat));
                        check({e.name, "_ad_count"}, 32'(nad), 32'(e.nad));
                        check({e.name, "_sh_count"}, 32'(nsh), 32'(W));
                    end
                    running = 1'b0;
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish within 20000 cycles required finish");
        $fatal(1);
    end

    task automatic wait_idle();
        int t = 0;
        while (!bus.idle && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        check("wait_idle_timeout", 32'(bus.idle), 32'd1);
    endtask

    task automatic wait_drain(input int depth);
        int t = 0;
        while (sb.size() > depth && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        check("wait_done_timeout", 32'(sb.size()), 32'(depth));
    endtask

    task automatic drive(input bit s, input logic [7:0] a, input logic [7:0] b);
        bus.st     = 1'b1;
        bus.sgn    = s;
        bus.mcand  = a;
        bus.mplier = b;
    endtask

    task automatic expect_op(input logic [15:0] p, input int lat, input int nad, input string name);
        exp_t e;
        e.prod = p; e.lat = lat; e.nad = nad; e.name = name;
        sb.push_back(e);
    endtask

    task automatic issue(input bit s, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] p, input int lat, input int nad, input string name);
        wait_idle();
        drive(s, a, b);
        expect_op(p, lat, nad, name);
        @(posedge clk); #2;
        bus.st = 1'b0;
        wait_drain(0);
    endtask

    initial begin : stimulus
        bus.st = 1'b0; bus.sgn = 1'b0; bus.mcand = '0; bus.mplier = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_idle",    32'(bus.idle),    32'd1);
        check("reset_done",    32'(bus.done),    32'd0);
        check("reset_product", 32'(bus.product), 32'd0);
        check("reset_state",   32'(bus.state),   32'd0);
        check("reset_load",    32'(bus.load),    32'd0);
        check("reset_sh",      32'(bus.sh),      32'd0);
        check("reset_ad",      32'(bus.ad),      32'd0);
        @(posedge clk); #2;

        issue(1'b0, 8'd13,  8'd11,  16'd143,    11, 3, "u13x11");
        issue(1'b0, 8'd200, 8'd0,   16'd0,      8,  0, "u200x0");
        issue(1'b0, 8'd255, 8'd255, 16'd65025,  16, 8, "u255x255");
        issue(1'b1, 8'hF9,  8'd6,   16'hFFD6,   10, 2, "s-7x6");
        issue(1'b0, 8'hF9,  8'd6,   16'h05D6,   10, 2, "u249x6");
        issue(1'b1, 8'h80,  8'h80,  16'h4000,   9,  1, "s-128x-128");
        issue(1'b1, 8'h80,  8'd127, 16'hC080,   15, 7, "s-128x127");
        issue(1'b1, 8'd5,   8'hFD,  16'hFFF1,   10, 2, "s5x-3");

        // A start pulse during S_ADD/S_SHIFT must neither queue nor disturb the result.
        wait_idle();
        drive(1'b0, 8'd7, 8'd3);
        expect_op(16'd21, 10, 2, "ignore_st");
        @(posedge clk); #2;
        bus.st = 1'b0;
        repeat (3) @(posedge clk);
        #2 drive(1'b0, 8'd99, 8'd99);
        @(posedge clk); #2;
        bus.st = 1'b0;
        wait_drain(0);
        repeat (6) @(posedge clk);
        #2 check("ignore_st_stays_idle", 32'(bus.idle), 32'd1);

        // st held high: each new load follows the previous done by one cycle.
        wait_idle();
        drive(1'b0, 8'd3, 8'd5);
        expect_op(16'd15, 10, 2, "b2b_1");
        @(posedge clk); #2;
        b2b = 1'b1;
        drive(1'b0, 8'd2, 8'd9);
        expect_op(16'd18, 10, 2, "b2b_2");
        wait_drain(1);
        @(posedge clk); #2;
        drive(1'b0, 8'd10, 8'd10);
        expect_op(16'd100, 10, 2, "b2b_3");
        wait_drain(1);
        @(posedge clk); #2;
        bus.st = 1'b0;
        wait_drain(0);
        b2b = 1'b0;

        // Reset five cycles into an operation: no done may follow.
        wait_idle();
        drive(1'b0, 8'd13, 8'd11);
        @(posedge clk); #2;
        bus.st = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_state",   32'(bus.state),   32'd0);
        check("midrst_idle",    32'(bus.idle),    32'd1);
        check("midrst_done",    32'(bus.done),    32'd0);
        check("midrst_product", 32'(bus.product), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #2 check("midrst_idle_after", 32'(bus.idle), 32'd1);
        check("midrst_product_after", 32'(bus.product), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
